// File: rtl/full_adder_pkg.sv
// Purpose: shared defaults for the full_adder block (operand width, output staging).
package full_adder_pkg;

  // Classic 1-bit full adder with a registered output stage.
  localparam int unsigned DEF_WIDTH   = 1;
  localparam int unsigned DEF_REG_OUT = 1;

endpackage : full_adder_pkg

// File: rtl/full_adder_fa_cell.sv
// Purpose: combinational 1-bit full adder cell, the ripple-chain leaf.
// Ports:
//   i_a, i_b  - operand bits
//   i_cin     - carry in
//   o_s       - sum bit
//   o_cout    - carry out
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  logic w_p;

  // Propagate term shared by sum and carry.
  assign w_p    = i_a ^ i_b;
  assign o_s    = w_p ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & w_p);

endmodule : fa_cell

// File: rtl/full_adder.sv
// Purpose: parameterised ripple-carry full adder, {C_out,S} = A + B + C_in,
//          with an optional valid-qualified output register.
// Ports:
//   clk, rst_n - clock (rising edge) and async active-low reset
//   in_valid   - A/B/C_in qualified this cycle
//   A, B       - unsigned operands, WIDTH bits
//   C_in       - carry in
//   S          - sum, WIDTH bits
//   C_out      - carry out of the MSB
//   out_valid  - S/C_out hold a new result
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned REG_OUT = DEF_REG_OUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             out_valid
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  assign w_carry[0] = C_in;

  // Ripple chain, carries flow LSB -> MSB.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    fa_cell u_cell (
      .i_a    (A[i]),
      .i_b    (B[i]),
      .i_cin  (w_carry[i]),
      .o_s    (w_sum[i]),
      .o_cout (w_carry[i+1])
    );
  end

  if (REG_OUT != 0) begin : g_reg
    logic [WIDTH-1:0] r_s;
    logic             r_c_out;
    logic             r_out_valid;

    // Result register: loads only on valid, pulses valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s         <= '0;
        r_c_out     <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= in_valid;
        if (in_valid) begin
          r_s     <= w_sum;
          r_c_out <= w_carry[WIDTH];
        end
      end
    end

    assign S         = r_s;
    assign C_out     = r_c_out;
    assign out_valid = r_out_valid;
  end else begin : g_comb
    // Clock and reset have no role in the bypass configuration.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst_n;

    assign S         = w_sum;
    assign C_out     = w_carry[WIDTH];
    assign out_valid = in_valid;
  end

endmodule : full_adder

// File: tb/tb_full_adder.sv
`timescale 1ns/1ps
module tb_full_adder;

  logic clk;
  logic rst_n;

  // WIDTH=1, registered
  logic       a_vld, a_A, a_B, a_Ci, a_S, a_Co, a_ov;
  // WIDTH=8, registered
  logic       b_vld, b_Ci, b_Co, b_ov;
  logic [7:0] b_A, b_B, b_S;
  // WIDTH=1, combinational
  logic       c_vld, c_A, c_B, c_Ci, c_S, c_Co, c_ov;

  int n_cmp;
  int n_err;

  full_adder #(.WIDTH(1), .REG_OUT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_vld), .A(a_A), .B(a_B), .C_in(a_Ci),
    .S(a_S), .C_out(a_Co), .out_valid(a_ov)
  );

  full_adder #(.WIDTH(8), .REG_OUT(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_vld), .A(b_A), .B(b_B), .C_in(b_Ci),
    .S(b_S), .C_out(b_Co), .out_valid(b_ov)
  );

  full_adder #(.WIDTH(1), .REG_OUT(0)) u_dutc (
    .clk(clk), .rst_n(rst_n), .in_valid(c_vld), .A(c_A), .B(c_B), .C_in(c_Ci),
    .S(c_S), .C_out(c_Co), .out_valid(c_ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain unsigned addition, no truncation.
  function automatic logic [31:0] ref_add(input int unsigned a, input int unsigned b,
                                          input int unsigned c);
    return a + b + c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [2:0] v;
    logic [7:0] ra, rb;
    logic       rc;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    a_vld = 1'b0; a_A = 1'b0; a_B = 1'b0; a_Ci = 1'b0;
    b_vld = 1'b0; b_A = 8'h00; b_B = 8'h00; b_Ci = 1'b0;
    c_vld = 1'b0; c_A = 1'b0; c_B = 1'b0; c_Ci = 1'b0;

    // Reset state before any clock edge
    #2;
    chk("rst_w1_sum", 32'({a_Co, a_S}), 32'd0);
    chk("rst_w1_vld", 32'(a_ov), 32'd0);
    chk("rst_w8_sum", 32'({b_Co, b_S}), 32'd0);
    chk("rst_w8_vld", 32'(b_ov), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: truth table, one-cycle latency
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      @(negedge clk);
      a_A = v[2]; a_B = v[1]; a_Ci = v[0]; a_vld = 1'b1;
      @(posedge clk); #1;
      chk("t1_sum", 32'({a_Co, a_S}), ref_add(32'(v[2]), 32'(v[1]), 32'(v[0])));
      chk("t1_vld", 32'(a_ov), 32'd1);
    end

    // T3: valid pulse then hold
    @(negedge clk);
    a_A = 1'b0; a_B = 1'b1; a_Ci = 1'b1; a_vld = 1'b1;
    @(posedge clk); #1;
    chk("t3_load", 32'({a_Co, a_S}), 32'b10);
    chk("t3_vld1", 32'(a_ov), 32'd1);
    @(negedge clk);
    a_A = 1'b0; a_B = 1'b0; a_Ci = 1'b0; a_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t3_hold", 32'({a_Co, a_S}), 32'b10);
      chk("t3_vld0", 32'(a_ov), 32'd0);
    end

    // T2: async reset between edges, then first valid after release
    @(negedge clk);
    a_A = 1'b1; a_B = 1'b0; a_Ci = 1'b1; a_vld = 1'b1;
    b_A = 8'h5A; b_B = 8'hC3; b_Ci = 1'b1; b_vld = 1'b1;
    @(posedge clk); #1;
    chk("t2_pre_w1", 32'({a_Co, a_S}), 32'b10);
    chk("t2_pre_w8", 32'({b_Co, b_S}), ref_add(32'h5A, 32'hC3, 32'd1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("t2_rst_w1", 32'({a_Co, a_S, a_ov}), 32'd0);
    chk("t2_rst_w8", 32'({b_Co, b_S, b_ov}), 32'd0);
    a_vld = 1'b0; b_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a_A = 1'b1; a_B = 1'b1; a_Ci = 1'b1; a_vld = 1'b1;
    #1;
    chk("t2_nolat", 32'({a_Co, a_S, a_ov}), 32'd0);
    @(posedge clk); #1;
    chk("t2_first", 32'({a_Co, a_S}), 32'b11);
    chk("t2_vld", 32'(a_ov), 32'd1);
    @(negedge clk);
    a_vld = 1'b0;

    // T4: WIDTH=8 boundaries
    @(negedge clk);
    b_A = 8'hFF; b_B = 8'h00; b_Ci = 1'b1; b_vld = 1'b1;
    @(posedge clk); #1;
    chk("t4_ripple", 32'({b_Co, b_S}), 32'h100);
    @(negedge clk);
    b_A = 8'hFF; b_B = 8'hFF; b_Ci = 1'b1;
    @(posedge clk); #1;
    chk("t4_allones", 32'({b_Co, b_S}), 32'h1FF);
    @(negedge clk);
    b_A = 8'h00; b_B = 8'h00; b_Ci = 1'b0;
    @(posedge clk); #1;
    chk("t4_zero", 32'({b_Co, b_S}), 32'h000);

    // T5: back-to-back random vectors, exact one-cycle latency
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      @(negedge clk);
      b_A = ra; b_B = rb; b_Ci = rc; b_vld = 1'b1;
      @(posedge clk); #1;
      chk("t5_sum", 32'({b_Co, b_S}), ref_add(32'(ra), 32'(rb), 32'(rc)));
      chk("t5_vld", 32'(b_ov), 32'd1);
    end
    @(negedge clk);
    b_vld = 1'b0;
    @(posedge clk); #1;
    chk("t5_vld_end", 32'(b_ov), 32'd0);

    // T6: combinational configuration, same-step results
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      c_A = v[2]; c_B = v[1]; c_Ci = v[0]; c_vld = v[0] ^ v[2];
      #1;
      chk("t6_sum", 32'({c_Co, c_S}), ref_add(32'(v[2]), 32'(v[1]), 32'(v[0])));
      chk("t6_vld", 32'(c_ov), 32'(v[0] ^ v[2]));
      #99;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_full_adder
